// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/DIV registers and a circular
// transmit FIFO that feeds a registered serializer.
module mmio_uart_tx #(
  parameter logic [31:0] BASE      = 32'h0000_1000,
  parameter int unsigned DEPTH     = 8,
  parameter logic [15:0] DIV_RESET = 16'd433
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        tx,
  output logic        irq
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic       sel;
  logic [1:0] offset;
  logic       wr_txdata, wr_status, wr_div;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic          full, empty, push, pop;
  logic          overflow_q;
  logic [15:0]   div_q;

  logic [1:0]  state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [15:0] reload_q, reload_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  idx_q, idx_d;
  logic        tx_q, tx_d;
  logic        bit_end, load_frame;

  logic unused_bits;
  assign unused_bits = ^{WriteData[31:16], DataAdr[1:0]};

  assign sel       = (DataAdr[31:4] == BASE[31:4]);
  assign offset    = DataAdr[3:2];
  assign wr_txdata = MemWrite && sel && (offset == 2'd0);
  assign wr_status = MemWrite && sel && (offset == 2'd1);
  assign wr_div    = MemWrite && sel && (offset == 2'd2);

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  // A pop on the same edge frees a slot, so a push to a full FIFO still lands.
  assign push  = wr_txdata && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= WriteData[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      div_q      <= DIV_RESET;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
      if (wr_status)                overflow_q <= 1'b0;
      else if (wr_txdata && !push)  overflow_q <= 1'b1;
      if (wr_div) div_q <= WriteData[15:0];
    end
  end

  assign bit_end = (timer_q == 16'd0);

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    reload_d   = reload_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    tx_d       = tx_q;
    load_frame = 1'b0;
    pop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) load_frame = 1'b1;
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          timer_d = reload_q;
          idx_d   = 3'd0;
          tx_d    = shift_q[0];
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          timer_d = reload_q;
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (!empty) begin
            load_frame = 1'b1;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
    // DIV is captured only here, so a mid-frame DIV store affects the next frame.
    if (load_frame) begin
      pop      = 1'b1;
      shift_d  = mem_q[rptr_q];
      reload_d = div_q;
      timer_d  = div_q;
      tx_d     = 1'b0;
      state_d  = ST_START;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      timer_q  <= 16'd0;
      reload_q <= 16'd0;
      shift_q  <= 8'd0;
      idx_q    <= 3'd0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      reload_q <= reload_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      tx_q     <= tx_d;
    end
  end

  assign tx  = tx_q;
  assign irq = empty && (state_q == ST_IDLE);

  always_comb begin
    ReadData = 32'd0;
    if (sel) begin
      case (offset)
        2'd1: begin
          ReadData[0]      = full;
          ReadData[1]      = empty;
          ReadData[2]      = (state_q != ST_IDLE);
          ReadData[3]      = overflow_q;
          ReadData[8 +: CW] = count_q;
        end
        2'd2:    ReadData[15:0] = div_q;
        default: ReadData = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: register vector table, directed frame and
// FIFO corner sequences, and randomized traffic decoded by a UART receiver model.
module tb_mmio_uart_tx;

  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] A_TX  = BASE;
  localparam logic [31:0] A_ST  = BASE + 32'd4;
  localparam logic [31:0] A_DIV = BASE + 32'd8;
  localparam logic [31:0] A_R3  = BASE + 32'd12;

  logic        clk = 1'b0;
  logic        reset, MemWrite;
  logic [31:0] DataAdr, WriteData, ReadData;
  logic        tx, irq;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .BASE      (BASE),
    .DEPTH     (DEPTH),
    .DIV_RESET (16'd433)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .tx        (tx),
    .irq       (irq)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] status(input bit f, input bit e, input bit b, input bit o,
                                         input int cnt);
    logic [31:0] s;
    s = 32'd0;
    s[0] = f;
    s[1] = e;
    s[2] = b;
    s[3] = o;
    s[11:8] = cnt[3:0];
    return s;
  endfunction

  // Bit k of an 8N1 frame: start, eight data bits LSB first, stop.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    DataAdr   = a;
    WriteData = d;
    MemWrite  = 1'b1;
    @(posedge clk);
    #1;
    MemWrite  = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, output logic [31:0] d);
    DataAdr  = a;
    MemWrite = 1'b0;
    #1;
    d = ReadData;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int w;
    w = 0;
    while (irq !== 1'b1 && w < budget) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk(name, irq, 1);
  endtask

  task automatic count_lows(input int cycles, input string name);
    int lows;
    lows = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk(name, lows, 0);
  endtask

  // Receiver model: find the start edge, sample every bit at its centre.
  task automatic rx_frames(input int n, input int div);
    int waited;
    logic [7:0] got, want;
    for (int i = 0; i < n; i++) begin
      waited = 0;
      @(negedge clk);
      while (tx !== 1'b0 && waited < 5000) begin
        @(negedge clk);
        waited++;
      end
      if (tx !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL rx_timeout: frame %0d start bit not seen, tx=%b required 0", i, tx);
        return;
      end
      repeat (div / 2) @(negedge clk);
      chk("rx_start_bit", tx, 0);
      for (int b = 0; b < 8; b++) begin
        repeat (div + 1) @(negedge clk);
        got[b] = tx;
      end
      repeat (div + 1) @(negedge clk);
      chk("rx_stop_bit", tx, 1);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_extra_frame: got byte %h, required no frame", got);
      end else begin
        want = exp_q.pop_front();
        chk($sformatf("rx_byte%0d", i), got, want);
      end
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int div, n, g, guard;
    logic [7:0] b;

    reset     = 1'b0;
    MemWrite  = 1'b0;
    DataAdr   = A_ST;
    WriteData = 32'd0;

    tbl[0]  = '{1'b0, A_ST,          32'h0,         32'h0000_0002};
    tbl[1]  = '{1'b0, A_DIV,         32'h0,         32'd433};
    tbl[2]  = '{1'b1, A_DIV,         32'h1234_ABCD, 32'd433};
    tbl[3]  = '{1'b0, A_DIV,         32'h0,         32'h0000_ABCD};
    tbl[4]  = '{1'b0, A_DIV | 32'd3, 32'h0,         32'h0000_ABCD};
    tbl[5]  = '{1'b0, A_TX,          32'h0,         32'h0};
    tbl[6]  = '{1'b0, A_R3,          32'h0,         32'h0};
    tbl[7]  = '{1'b1, A_R3,          32'hFFFF_FFFF, 32'h0};
    tbl[8]  = '{1'b0, A_DIV,         32'h0,         32'h0000_ABCD};
    tbl[9]  = '{1'b0, 32'h0000_2008, 32'h0,         32'h0};
    tbl[10] = '{1'b1, 32'h0000_2008, 32'h0000_5555, 32'h0};
    tbl[11] = '{1'b0, A_DIV,         32'h0,         32'h0000_ABCD};
    tbl[12] = '{1'b1, A_ST,          32'hFFFF_FFFF, 32'h0000_0002};
    tbl[13] = '{1'b0, A_ST,          32'h0,         32'h0000_0002};
    tbl[14] = '{1'b1, A_DIV,         32'h0000_0003, 32'h0000_ABCD};
    tbl[15] = '{1'b0, A_DIV,         32'h0,         32'h0000_0003};

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx", tx, 1);
    chk("reset_irq", irq, 1);
    chk("reset_status_in_reset", ReadData, 32'h2);
    reset = 1'b1;
    @(posedge clk);
    #1;
    load(A_ST, rd);
    chk("idle_status", rd, 32'h2);
    load(A_DIV, rd);
    chk("idle_div", rd, 32'd433);
    chk("idle_tx", tx, 1);
    chk("idle_irq", irq, 1);

    // Register vector table; each read is taken before the edge that commits a store
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      DataAdr   = tbl[i].adr;
      WriteData = tbl[i].wd;
      MemWrite  = tbl[i].we;
      #1;
      chk($sformatf("reg_vec%0d", i), ReadData, tbl[i].exp);
      @(posedge clk);
      #1;
      MemWrite = 1'b0;
    end
    chk("reg_irq", irq, 1);

    // Single byte, DIV=3
    store(A_TX, 32'hFFFF_FFA5);
    chk("single_no_same_edge_pop", tx, 1);
    load(A_ST, rd);
    chk("single_count_after_push", rd, status(0, 0, 0, 0, 1));
    @(posedge clk);
    #1;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("single_bit%0d", k), tx, frame_bit(8'hA5, k));
      if (k < 9) begin
        repeat (4) @(posedge clk);
        #1;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    chk("single_busy_end_of_stop", irq, 0);
    @(posedge clk);
    #1;
    chk("single_irq_after_frame", irq, 1);
    load(A_ST, rd);
    chk("single_status_after", rd, 32'h2);

    // Back-to-back, DIV=0
    store(A_DIV, 32'd0);
    DataAdr   = A_TX;
    WriteData = 32'h55;
    MemWrite  = 1'b1;
    @(posedge clk);
    #1;
    WriteData = 32'h0F;
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    load(A_ST, rd);
    chk("b2b_count_one", rd, status(0, 0, 1, 0, 1));
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("b2b_bit%0d", k), tx, frame_bit((k < 10) ? 8'h55 : 8'h0F, k % 10));
      @(posedge clk);
      #1;
    end
    chk("b2b_tx_idle", tx, 1);
    chk("b2b_irq", irq, 1);

    // Overflow, DIV=100: DEPTH+1 frames expected, last store dropped
    store(A_DIV, 32'd100);
    exp_q.delete();
    for (int i = 0; i <= DEPTH; i++) exp_q.push_back(8'(8'h30 + i));
    fork
      begin
        for (int i = 0; i < DEPTH + 2; i++) begin
          DataAdr   = A_TX;
          WriteData = 32'h30 + i;
          MemWrite  = 1'b1;
          @(posedge clk);
          #1;
        end
        MemWrite = 1'b0;
        load(A_ST, rd);
        chk("ovf_status", rd, status(1, 0, 1, 1, DEPTH));
        chk("ovf_irq_low", irq, 0);
        store(A_ST, 32'd0);
        load(A_ST, rd);
        chk("ovf_cleared", rd, status(1, 0, 1, 0, DEPTH));
      end
      rx_frames(DEPTH + 1, 100);
    join
    wait_idle(2000, "ovf_drain_irq");
    chk("ovf_queue_drained", exp_q.size(), 0);
    count_lows(300, "ovf_no_extra_frame");

    // Full FIFO with a push on the exact edge STOP ends, DIV=2
    store(A_DIV, 32'd2);
    @(posedge clk);
    #1;
    for (int i = 0; i <= DEPTH; i++) begin
      DataAdr   = A_TX;
      WriteData = 32'h40 + i;
      MemWrite  = 1'b1;
      @(posedge clk);
      #1;
    end
    MemWrite = 1'b0;
    load(A_ST, rd);
    chk("corner_full_before", rd, status(1, 0, 1, 0, DEPTH));
    // First pop at N+1, the next one 10*(DIV+1) edges later; now at edge N+DEPTH.
    repeat (30 - DEPTH) @(posedge clk);
    #1;
    store(A_TX, 32'hC3);
    load(A_ST, rd);
    chk("corner_push_pop_full", rd, status(1, 0, 1, 0, DEPTH));
    chk("corner_no_gap_start", tx, 0);
    store(A_TX, 32'h99);
    load(A_ST, rd);
    chk("corner_plain_overflow", rd, status(1, 0, 1, 1, DEPTH));
    store(A_ST, 32'd0);
    wait_idle((DEPTH + 2) * 30 + 100, "corner_drain_irq");

    // Reset during DATA bit 3, DIV=7
    store(A_DIV, 32'd7);
    store(A_TX, 32'h00);
    store(A_TX, 32'h11);
    repeat (35) @(posedge clk);
    #1;
    chk("midframe_bit3_low", tx, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("midframe_async_tx_high", tx, 1);
    chk("midframe_irq", irq, 1);
    load(A_ST, rd);
    chk("midframe_status_in_reset", rd, 32'h2);
    @(posedge clk);
    #1;
    reset = 1'b1;
    load(A_ST, rd);
    chk("post_reset_status", rd, 32'h2);
    load(A_DIV, rd);
    chk("post_reset_div", rd, 32'd433);
    count_lows(200, "post_reset_no_frame");

    // Randomized traffic checked by the receiver model
    for (int r = 0; r < 4; r++) begin
      div = $urandom_range(0, 4);
      store(A_DIV, div);
      n = $urandom_range(4, 12);
      exp_q.delete();
      fork
        begin
          for (int i = 0; i < n; i++) begin
            guard = 0;
            load(A_ST, rd);
            while (rd[0] && guard < 5000) begin
              @(posedge clk);
              #1;
              load(A_ST, rd);
              guard++;
            end
            if (rd[0]) begin
              checks++;
              errors++;
              $display("FAIL rand_poll_timeout: full=%b required 0", rd[0]);
            end
            b = 8'($urandom);
            exp_q.push_back(b);
            store(A_TX, {24'($urandom), b});
            g = $urandom_range(0, 3);
            repeat (g) @(posedge clk);
            #1;
          end
        end
        rx_frames(n, div);
      join
      wait_idle(500, "rand_drain_irq");
      chk("rand_queue_drained", exp_q.size(), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
